// File: rtl/experiment1_nios2_qsys_0_oci_monitor_mem_pkg.sv
// Shared definitions for the OCI monitor memory: FSM states, jdo field
// positions and the default word-address width.
package experiment1_nios2_qsys_0_oci_monitor_mem_pkg;

  localparam int ADDR_W_DEFAULT = 8;

  localparam int JDO_W         = 38;
  localparam int JDO_RD_FLAG   = 35;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    J_RD     = 3'd1,
    J_RD_CAP = 3'd2,
    J_WR     = 3'd3,
    C_RD     = 3'd4,
    C_RD_CAP = 3'd5,
    C_ACK    = 3'd6
  } mon_state_t;

endpackage

// File: rtl/experiment1_nios2_qsys_0_oci_monitor_ram.sv
// Single-port 32-bit RAM with byte enables and a registered read port
// (one-cycle latency, read-during-write returns the old word). No reset.
module experiment1_nios2_qsys_0_oci_monitor_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/experiment1_nios2_qsys_0_oci_monitor_mem.sv
// OCI monitor memory: debug RAM shared between JTAG strobes and a CPU
// Avalon slave port, arbitrated by a single FSM (JTAG wins ties).
module experiment1_nios2_qsys_0_oci_monitor_mem
  import experiment1_nios2_qsys_0_oci_monitor_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output mon_state_t        state_dbg
);

  mon_state_t        state;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0]       jtag_wdata;
  logic              load_done;
  logic              strobe_any;

  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_FLAG+1], jdo[JDO_WDATA_LSB-1:0]};

  assign strobe_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign state_dbg   = state;
  assign waitrequest = (read | write) & (state != C_RD_CAP) & (state != C_ACK);

  // In IDLE the RAM is pointed at the CPU address so a CPU read has its
  // data ready by the time C_RD hands over to C_RD_CAP.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = byteenable;
    ram_addr  = address;
    ram_wdata = writedata;
    case (state)
      J_RD:  ram_addr = jtag_addr;
      J_WR: begin
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_addr  = jtag_addr;
        ram_wdata = jtag_wdata;
      end
      C_ACK: ram_we = write & debugaccess;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      jtag_addr     <= '0;
      jtag_wdata    <= '0;
      load_done     <= 1'b0;
      MonDReg       <= '0;
      readdata      <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_done) monitor_ready <= 1'b1;
      if (state != IDLE && strobe_any) monitor_error <= 1'b1;
      case (state)
        IDLE: begin
          if (take_action_ocimem_b) begin
            monitor_ready <= 1'b0;
            jtag_wdata    <= jdo[JDO_WDATA_LSB +: 32];
            state         <= J_WR;
          end else if (take_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            jtag_addr     <= jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_RD_FLAG]) state <= J_RD;
            else                  load_done <= 1'b1;
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            jtag_addr     <= jtag_addr + 1'b1;
            state         <= J_RD;
          end else if (read) begin
            state <= C_RD;
          end else if (write) begin
            state <= C_ACK;
          end
        end
        J_RD:     state <= J_RD_CAP;
        J_RD_CAP: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        J_WR: begin
          jtag_addr     <= jtag_addr + 1'b1;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        C_RD: begin
          readdata <= ram_q;
          state    <= C_RD_CAP;
        end
        C_RD_CAP: state <= IDLE;
        C_ACK:    state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  experiment1_nios2_qsys_0_oci_monitor_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_experiment1_nios2_qsys_0_oci_monitor_mem.sv
// Directed bench for the OCI monitor memory: JTAG and CPU paths, arbitration,
// busy-strobe error, wrap-around, debugaccess gating and reset behaviour.
module tb_experiment1_nios2_qsys_0_oci_monitor_mem;
  import experiment1_nios2_qsys_0_oci_monitor_mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        waitrequest;
  mon_state_t  state_dbg;

  int checks = 0;
  int errors = 0;

  experiment1_nios2_qsys_0_oci_monitor_mem #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .state_dbg               (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    v[35] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  // driver tasks
  task automatic jtag_load(input logic [7:0] a);
    jdo = jdo_a(a, 1'b0); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
  endtask

  task automatic jtag_write(input logic [31:0] d);
    jdo = jdo_b(d); take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
  endtask

  task automatic jtag_read(input logic [7:0] a, output logic [31:0] d);
    jdo = jdo_a(a, 1'b1); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    tick();
    d = MonDReg;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg);
    address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
    tick();
    tick();
    write = 1'b0; debugaccess = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    read = 1'b1;
    #1;
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait_rd: got %b expected 1", waitrequest); end
    read = 1'b0;
    #1;
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait_idle: got %b expected 0", waitrequest); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg: got %h expected 00000000", MonDReg); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", readdata); end
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", monitor_ready); end
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", monitor_error); end
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
  endtask

  task automatic test_write_readback();
    logic [31:0] d;
    jdo = jdo_a(8'h10, 1'b0); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL load_ready_clr: got %b expected 0", monitor_ready); end
    tick();
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL load_ready_set: got %b expected 1", monitor_ready); end
    jdo = jdo_b(32'hDEADBEEF); take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    checks++;
    if (monitor_ready !== 1'b0 || state_dbg !== J_WR) begin
      errors++; $display("FAIL write_busy: got ready=%b state=%0d expected ready=0 state=%0d", monitor_ready, state_dbg, J_WR);
    end
    tick();
    jdo = jdo_a(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    checks++;
    if (MonDReg !== 32'h0) begin errors++; $display("FAIL read_early: got %h expected 00000000", MonDReg); end
    tick();
    checks++;
    if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL read_back: got %h expected deadbeef", MonDReg); end
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b expected 1", monitor_ready); end
    // address is back at 0x10 after the read; write 0x11, then step with no_action
    jtag_load(8'h11);
    jtag_write(32'hCAFEF00D);
    jtag_load(8'h10);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    tick();
    d = MonDReg;
    checks++;
    if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL incr_read: got %h expected cafef00d", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    jtag_load(8'hFF);
    jtag_write(32'h1);
    jtag_write(32'h2);
    jtag_read(8'hFF, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL wrap_ff: got %h expected 00000001", d); end
    jtag_read(8'h00, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL wrap_00: got %h expected 00000002", d); end
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", monitor_error); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    jtag_load(8'h21);
    jtag_write(32'h11111111);
    jtag_load(8'h20);
    jdo = jdo_b(32'h0000AAAA); take_action_ocimem_b = 1'b1;
    tick();
    jdo = jdo_b(32'h0000BBBB);
    tick();
    take_action_ocimem_b = 1'b0;
    checks++;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL busy_err_set: got %b expected 1", monitor_error); end
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    tick();
    checks++;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL busy_err_hold: got %b expected 1", monitor_error); end
    jtag_read(8'h21, d);
    checks++;
    if (d !== 32'h11111111) begin errors++; $display("FAIL busy_dropped: got %h expected 11111111", d); end
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL busy_err_clr: got %b expected 0", monitor_error); end
    jtag_read(8'h20, d);
    checks++;
    if (d !== 32'h0000AAAA) begin errors++; $display("FAIL busy_first: got %h expected 0000aaaa", d); end
  endtask

  task automatic test_debugaccess();
    logic [31:0] d;
    jtag_load(8'h03);
    jtag_write(32'h0BADF00D);
    address = 8'h03; writedata = 32'h12345678; byteenable = 4'hF; debugaccess = 1'b0; write = 1'b1;
    #1;
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL cwr_wait_idle: got %b expected 1", waitrequest); end
    tick();
    checks++;
    if (waitrequest !== 1'b0 || state_dbg !== C_ACK) begin
      errors++; $display("FAIL cwr_ack: got wait=%b state=%0d expected wait=0 state=%0d", waitrequest, state_dbg, C_ACK);
    end
    tick();
    write = 1'b0;
    jtag_read(8'h03, d);
    checks++;
    if (d !== 32'h0BADF00D) begin errors++; $display("FAIL cwr_gated: got %h expected 0badf00d", d); end
    cpu_write(8'h03, 32'h12345678, 4'hF, 1'b1);
    jtag_read(8'h03, d);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL cwr_dbg: got %h expected 12345678", d); end
    cpu_write(8'h03, 32'hAAAABBBB, 4'b0011, 1'b1);
    jtag_read(8'h03, d);
    checks++;
    if (d !== 32'h1234BBBB) begin errors++; $display("FAIL cwr_bytes: got %h expected 1234bbbb", d); end
  endtask

  task automatic test_simultaneous();
    int high_cycles;
    bit done;
    cpu_write(8'h05, 32'h55AA55AA, 4'hF, 1'b1);
    jtag_load(8'h40);
    jtag_write(32'h40404040);
    address = 8'h05; read = 1'b1;
    jdo = jdo_a(8'h40, 1'b1); take_action_ocimem_a = 1'b1;
    #1;
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL sim_wait0: got %b expected 1", waitrequest); end
    tick();
    take_action_ocimem_a = 1'b0;
    checks++;
    if (state_dbg !== J_RD) begin errors++; $display("FAIL sim_jtag_first: got %0d expected %0d", state_dbg, J_RD); end
    // waitrequest-high cycles following the strobe cycle, until the CPU read completes
    high_cycles = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (waitrequest === 1'b0) done = 1;
      else begin high_cycles++; tick(); end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL sim_timeout: got waitrequest stuck=%b expected 0 within 10 cycles", waitrequest); end
    checks++;
    if (high_cycles != 4) begin errors++; $display("FAIL sim_wait_cycles: got %0d expected 4", high_cycles); end
    checks++;
    if (readdata !== 32'h55AA55AA) begin errors++; $display("FAIL sim_readdata: got %h expected 55aa55aa", readdata); end
    checks++;
    if (MonDReg !== 32'h40404040) begin errors++; $display("FAIL sim_mondreg: got %h expected 40404040", MonDReg); end
    tick();
    read = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    jdo = jdo_a(8'h40, 1'b1); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    checks++;
    if (state_dbg !== J_RD) begin errors++; $display("FAIL rmid_in_jrd: got %0d expected %0d", state_dbg, J_RD); end
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if (MonDReg !== 32'h0) begin errors++; $display("FAIL rmid_mondreg: got %h expected 00000000", MonDReg); end
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", monitor_ready); end
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL rmid_state: got %0d expected %0d", state_dbg, IDLE); end
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    address = '0;
    read = 1'b0;
    write = 1'b0;
    writedata = '0;
    byteenable = 4'hF;
    debugaccess = 1'b0;
    test_reset();
    test_write_readback();
    test_wrap();
    test_back_to_back();
    test_debugaccess();
    test_simultaneous();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
